// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback and drives data_path controls.
// Define MC_MEM_WAIT_EN to enable the mem_ready wait-state handshake and the memory timeout counter.
module mc_control_fsm #(
    parameter int unsigned n           = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] inst,
    input  logic         mem_ready,
    output logic         pc_write,
    output logic         adr_src,
    output logic         ir_write,
    output logic         mem_write,
    output logic         reg_write,
    output logic         branch,
    output logic [1:0]   result_src,
    output logic [1:0]   alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   ALUOp,
    output logic         retire,
    output logic         mem_err,
    output logic [3:0]   state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_ERROR    = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [3:0] state_q, state_d;
    logic       mem_err_q, mem_err_d;
    logic       rdy;
    logic       timeout;
    logic [6:0] opcode;

    // Only the opcode field steers the sequence.
    logic [n-8:0] unused_inst;
    assign unused_inst = inst[n-1:7];
    assign opcode      = inst[6:0];

`ifdef MC_MEM_WAIT_EN
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             in_mem_state;

    assign rdy          = mem_ready;
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout      = in_mem_state && !mem_ready && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // Counts consecutive not-ready cycles while parked in one memory state.
    always_comb begin
        wait_cnt_d = '0;
        if (in_mem_state && !mem_ready && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Memory always completes in one cycle; timeout configuration is kept only for port/parameter compatibility.
    logic [CNT_W:0] unused_cfg;
    assign unused_cfg = {mem_ready, CNT_W'(MEM_TIMEOUT)};
    assign rdy        = 1'b1;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next-state and Moore output decode; reset forces every control low.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        ALUOp      = 2'b00;
        retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (timeout)  state_d = S_ERROR;
                else if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECUTER;
                    OP_I:              state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_ERROR;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (timeout)  state_d = S_ERROR;
                else if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (timeout)  state_d = S_ERROR;
                else if (rdy) state_d = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            S_ALUWB, S_BEQ:                state_d = S_FETCH;
            S_ERROR:                       state_d = S_ERROR;
            default:                       state_d = S_ERROR;
        endcase

        mem_err_d = mem_err_q || (state_d == S_ERROR);

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = rdy;
                    pc_write   = rdy;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: adr_src = 1'b1;
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    retire    = rdy;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_EXECUTER: begin
                    alu_src_a = 2'b10;
                    ALUOp     = 2'b10;
                end
                S_EXECUTEI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    ALUOp     = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = 2'b10;
                    ALUOp     = 2'b01;
                    branch    = 1'b1;
                    retire    = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_err = mem_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm; build-dependent wait-state vectors follow MC_MEM_WAIT_EN.
module tb_mc_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, irw, mw, rw, br;
        logic [1:0] rs, a, b, op;
        logic       ret, err;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic        rdy;
        exp_t        exp;
    } vec_t;

    localparam logic [31:0] I_ADDI = 32'h00A00293;
    localparam logic [31:0] I_ADD  = 32'h005302B3;
    localparam logic [31:0] I_LW   = 32'h0002A303;
    localparam logic [31:0] I_SW   = 32'h0062A023;
    localparam logic [31:0] I_BEQ  = 32'h00628463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic        mem_ready;
    logic        pc_write, adr_src, ir_write, mem_write, reg_write, branch, retire, mem_err;
    logic [1:0]  result_src, alu_src_a, alu_src_b, ALUOp;
    logic [3:0]  state;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    exp_t X_RST, X_FR, X_FW, X_DEC, X_MADR, X_MRD, X_MWB, X_MWRR, X_MWRW;
    exp_t X_EXR, X_EXI, X_AWB, X_BEQ, X_JAL, X_ERR;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .inst       (inst),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .branch     (branch),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALUOp      (ALUOp),
        .retire     (retire),
        .mem_err    (mem_err),
        .state      (state)
    );

    function automatic exp_t mk(input logic [3:0] st, input logic pcw, input logic adr, input logic irw,
                                input logic mw, input logic rw, input logic br, input logic [1:0] rs,
                                input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                                input logic ret, input logic err);
        exp_t e;
        e = {st, pcw, adr, irw, mw, rw, br, rs, a, b, op, ret, err};
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t act;
        act = {state, pc_write, adr_src, ir_write, mem_write, reg_write, branch,
               result_src, alu_src_a, alu_src_b, ALUOp, retire, mem_err};
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                     name, act.st, act, e.st, e);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic r, input exp_t e);
        vec_t v;
        v.inst = i;
        v.rdy  = r;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    // Each vector: drive inputs mid-cycle, check outputs, then advance one clock.
    task automatic run_all(input string tag);
        foreach (vecs[k]) begin
            inst      = vecs[k].inst;
            mem_ready = vecs[k].rdy;
            #1;
            check($sformatf("%s[%0d]", tag, k), vecs[k].exp);
            @(posedge clk);
            #2;
        end
        vecs.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        //           st  pcw adr irw mw rw br  rs     a      b      op     ret err
        X_RST  = mk(4'd0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        X_FR   = mk(4'd0,  1, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
        X_FW   = mk(4'd0,  0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
        X_DEC  = mk(4'd1,  0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
        X_MADR = mk(4'd2,  0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
        X_MRD  = mk(4'd3,  0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        X_MWB  = mk(4'd4,  0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
        X_MWRR = mk(4'd5,  0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        X_MWRW = mk(4'd5,  0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        X_EXR  = mk(4'd6,  0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
        X_EXI  = mk(4'd7,  0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0);
        X_AWB  = mk(4'd8,  0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        X_BEQ  = mk(4'd9,  0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0);
        X_JAL  = mk(4'd10, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
        X_ERR  = mk(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

        reset     = 1'b1;
        inst      = I_ADDI;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_hold", X_RST);
        reset = 1'b0;
        #1;

        // Back-to-back instructions with memory always ready.
        push(I_ADDI, 1, X_FR); push(I_ADDI, 1, X_DEC); push(I_ADDI, 1, X_EXI);  push(I_ADDI, 1, X_AWB);
        push(I_ADD,  1, X_FR); push(I_ADD,  1, X_DEC); push(I_ADD,  1, X_EXR);  push(I_ADD,  1, X_AWB);
        push(I_LW,   1, X_FR); push(I_LW,   1, X_DEC); push(I_LW,   1, X_MADR); push(I_LW,   1, X_MRD);
        push(I_LW,   1, X_MWB);
        push(I_SW,   1, X_FR); push(I_SW,   1, X_DEC); push(I_SW,   1, X_MADR); push(I_SW,   1, X_MWRR);
        push(I_BEQ,  1, X_FR); push(I_BEQ,  1, X_DEC); push(I_BEQ,  1, X_BEQ);
        push(I_JAL,  1, X_FR); push(I_JAL,  1, X_DEC); push(I_JAL,  1, X_JAL);  push(I_JAL,  1, X_AWB);
        push(I_BAD,  1, X_FR); push(I_BAD,  1, X_DEC); push(I_BAD,  1, X_ERR);  push(I_BAD,  0, X_ERR);
        push(I_ADDI, 1, X_ERR);
        run_all("seq");

        reset = 1'b1;
        #1;
        check("reset_from_error", X_RST);
        @(posedge clk);
        #2;
        reset = 1'b0;

`ifdef MC_MEM_WAIT_EN
        // 15 not-ready FETCH cycles stay below the timeout; store stalls in MEMWRITE.
        for (int i = 0; i < 15; i++) push(I_SW, 0, X_FW);
        push(I_SW, 1, X_FR);   push(I_SW, 1, X_DEC); push(I_SW, 1, X_MADR);
        push(I_SW, 0, X_MWRW); push(I_SW, 0, X_MWRW); push(I_SW, 1, X_MWRR);
        // Load with three wait states: MEMWB on cycle 8.
        push(I_LW, 1, X_FR);  push(I_LW, 1, X_DEC); push(I_LW, 1, X_MADR);
        push(I_LW, 0, X_MRD); push(I_LW, 0, X_MRD); push(I_LW, 0, X_MRD); push(I_LW, 1, X_MRD);
        push(I_LW, 1, X_MWB);
        // 16 not-ready FETCH cycles time out.
        for (int i = 0; i < 16; i++) push(I_ADDI, 0, X_FW);
        push(I_ADDI, 0, X_ERR); push(I_ADDI, 1, X_ERR);
`else
        // mem_ready is ignored: every memory state lasts one cycle.
        push(I_SW,   0, X_FR); push(I_SW,   0, X_DEC); push(I_SW,   0, X_MADR); push(I_SW, 0, X_MWRR);
        push(I_LW,   0, X_FR); push(I_LW,   0, X_DEC); push(I_LW,   0, X_MADR); push(I_LW, 0, X_MRD);
        push(I_LW,   0, X_MWB);
        push(I_ADDI, 0, X_FR); push(I_ADDI, 0, X_DEC); push(I_ADDI, 0, X_EXI);  push(I_ADDI, 0, X_AWB);
        push(I_ADDI, 0, X_FR);
`endif
        run_all("wait");

        // Reset asserted in the middle of a store.
        pulse_reset();
        push(I_SW, 1, X_FR); push(I_SW, 1, X_DEC); push(I_SW, 1, X_MADR);
        run_all("st");
        inst      = I_SW;
        mem_ready = 1'b0;
        #1;
`ifdef MC_MEM_WAIT_EN
        check("memwrite_before_reset", X_MWRW);
`else
        check("memwrite_before_reset", X_MWRR);
`endif
        reset = 1'b1;
        #1;
        check("reset_mid_memwrite", X_RST);
        @(posedge clk);
        #2;
        check("reset_mid_memwrite_held", X_RST);
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("fetch_after_reset", X_FR);
        @(posedge clk);
        #2;
        check("decode_after_reset", X_DEC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
